// File: rtl/async_fifo_wr_arbiter_if.sv
// ---------------------------------------------------------------------------
// async_fifo_wr_arbiter_if
//
// Groups the requester handshake and the FIFO write port seen by the
// write-side arbiter.
//
//   req_valid [NREQ]        per-requester data valid
//   req_data  [NREQ*DSIZE]  requester i data at [i*DSIZE +: DSIZE]
//   req_ready [NREQ]        per-requester accept (from arbiter)
//   wfull                   FIFO full flag
//   winc                    FIFO write enable (from arbiter)
//   wdata     [DSIZE]       FIFO write data (from arbiter)
//
// master: the arbiter. slave: requesters + FIFO side.
// ---------------------------------------------------------------------------
interface async_fifo_wr_arbiter_if #(
    parameter int DSIZE = 8,
    parameter int NREQ  = 4
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*DSIZE-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic                  wfull;
    logic                  winc;
    logic [DSIZE-1:0]      wdata;

    modport master (
        input  req_valid,
        input  req_data,
        input  wfull,
        output req_ready,
        output winc,
        output wdata
    );

    modport slave (
        output req_valid,
        output req_data,
        output wfull,
        input  req_ready,
        input  winc,
        input  wdata
    );
endinterface

// File: rtl/async_fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// async_fifo_wr_arbiter
//
// Shares the single async-FIFO write port among NREQ requesters with
// round-robin arbitration and a per-grant burst limit of BURST words.
// Runs entirely in the write clock domain; writes are paced by wfull so a
// full FIFO is never written.
//
// Ports:
//   wclk       write-domain clock
//   wrst_n     synchronous active-low reset
//   bus        requester handshake + FIFO write port (master modport)
//   grant_vld  an owner currently holds the port (registered)
//   grant_id   current owner index (registered)
//   stall_cnt  cycles the owner was blocked by wfull, saturating at 0xFFFF
// ---------------------------------------------------------------------------
module async_fifo_wr_arbiter #(
    parameter int DSIZE = 8,
    parameter int NREQ  = 4,
    parameter int BURST = 4
) (
    input  logic                       wclk,
    input  logic                       wrst_n,
    async_fifo_wr_arbiter_if.master    bus,
    output logic                       grant_vld,
    output logic [$clog2(NREQ)-1:0]    grant_id,
    output logic [15:0]                stall_cnt
);
    localparam int IW = $clog2(NREQ);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_GRANT = 1'b1;

    localparam logic [4:0] BURST_LAST = 5'(BURST - 1);

    logic [0:0]      state;
    logic [IW-1:0]   owner;
    logic [4:0]      burst_cnt;

    logic            owner_vld;
    logic            owner_req;
    logic            xfer;
    logic            release_grant;
    logic            arbitrate;
    logic            stall_evt;
    logic            found;
    logic [IW-1:0]   next_owner;
    logic [IW-1:0]   cand;
    logic [NREQ-1:0] ready_vec;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign owner_vld = (state == S_GRANT);
    assign owner_req = bus.req_valid[owner];

    // Only the owner is ever ready; reset and a full FIFO both gate it off.
    always_comb begin
        ready_vec = '0;
        if (wrst_n && owner_vld && !bus.wfull) begin
            ready_vec[owner] = 1'b1;
        end
    end

    assign xfer          = owner_req && ready_vec[owner];
    assign release_grant = owner_vld && (!owner_req || (xfer && burst_cnt == BURST_LAST));
    assign arbitrate     = !owner_vld || release_grant;
    assign stall_evt     = owner_vld && owner_req && bus.wfull;

    // Round-robin search starting just after the current owner and ending on
    // the owner itself, so a lone requester is re-granted without a bubble.
    always_comb begin
        found      = 1'b0;
        next_owner = owner;
        cand       = owner;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IW'((int'(owner) + k) % NREQ);
            if (!found && bus.req_valid[cand]) begin
                found      = 1'b1;
                next_owner = cand;
            end
        end
    end

    assign bus.req_ready = ready_vec;
    assign bus.winc      = xfer;
    assign bus.wdata     = owner_vld ? bus.req_data[int'(owner)*DSIZE +: DSIZE] : '0;

    assign grant_vld = owner_vld;
    assign grant_id  = owner;

    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            state     <= S_IDLE;
            // Last index so the first search after reset begins at requester 0.
            owner     <= IW'(NREQ - 1);
            burst_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (arbitrate) begin
                burst_cnt <= '0;
                if (found) begin
                    state <= S_GRANT;
                    owner <= next_owner;
                end else begin
                    state <= S_IDLE;
                end
            end else if (xfer) begin
                burst_cnt <= burst_cnt + 5'd1;
            end

            if (stall_evt) begin
                stall_cnt <= sat_inc16(stall_cnt);
            end
        end
    end
endmodule

// File: tb/tb_async_fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_async_fifo_wr_arbiter
//
// Directed bench for async_fifo_wr_arbiter (DSIZE=8, NREQ=4, BURST=4).
// Each requester i presents words {i, n} (n = words already accepted); a
// write log records every FIFO write with the owner at that time.
// ---------------------------------------------------------------------------
module tb_async_fifo_wr_arbiter;
    localparam int DSIZE = 8;
    localparam int NREQ  = 4;
    localparam int BURST = 4;

    logic        wclk = 1'b0;
    logic        wrst_n;
    logic        grant_vld;
    logic [1:0]  grant_id;
    logic [15:0] stall_cnt;

    async_fifo_wr_arbiter_if #(.DSIZE(DSIZE), .NREQ(NREQ)) bus ();

    async_fifo_wr_arbiter #(.DSIZE(DSIZE), .NREQ(NREQ), .BURST(BURST)) dut (
        .wclk      (wclk),
        .wrst_n    (wrst_n),
        .bus       (bus),
        .grant_vld (grant_vld),
        .grant_id  (grant_id),
        .stall_cnt (stall_cnt)
    );

    always #5 wclk = ~wclk;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          rem  [NREQ];
    int          sent [NREQ];
    logic        hold [NREQ];
    logic [7:0]  wq_data [$];
    logic [1:0]  wq_gid  [$];

    task automatic apply_inputs();
        for (int i = 0; i < NREQ; i++) begin
            bus.req_valid[i] = (rem[i] > 0) && !hold[i];
            bus.req_data[i*DSIZE +: DSIZE] = 8'((i << 4) + sent[i]);
        end
    endtask

    // One clock: log the write and the accepts at the negedge, then advance
    // the requester sources just after the posedge.
    task automatic cycle();
        logic [NREQ-1:0] acc;
        @(negedge wclk);
        acc = bus.req_ready & bus.req_valid;
        if (bus.winc === 1'b1) begin
            wq_data.push_back(bus.wdata);
            wq_gid.push_back(grant_id);
        end
        @(posedge wclk);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (acc[i]) begin
                rem[i]--;
                sent[i]++;
            end
        end
        apply_inputs();
    endtask

    task automatic do_reset();
        wrst_n = 1'b0;
        bus.wfull = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            rem[i] = 0;
            sent[i] = 0;
            hold[i] = 1'b0;
        end
        apply_inputs();
        cycle();
        wrst_n = 1'b1;
        wq_data.delete();
        wq_gid.delete();
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if (grant_vld !== 1'b0 || grant_id !== 2'd3 || stall_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_state: vld=%b id=%0d stall=%0d, want vld=0 id=3 stall=0",
                     grant_vld, grant_id, stall_cnt);
        end
        rem[0] = 4;
        apply_inputs();
        cycle(); #1;
        wrst_n = 1'b0;
        #1;
        n_tests++;
        if (bus.winc !== 1'b0 || bus.req_ready !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_gating: winc=%b ready=%b, want winc=0 ready=0000",
                     bus.winc, bus.req_ready);
        end
        cycle(); #1;
        n_tests++;
        if (grant_vld !== 1'b0 || grant_id !== 2'd3 || wq_data.size() !== 0) begin
            n_fail++;
            $display("FAIL reset_abort: vld=%b id=%0d writes=%0d, want vld=0 id=3 writes=0",
                     grant_vld, grant_id, wq_data.size());
        end
        wrst_n = 1'b1;
    endtask

    task automatic test_single();
        do_reset();
        rem[2] = 6;
        apply_inputs();
        cycle(); #1;
        n_tests++;
        if (grant_vld !== 1'b1 || grant_id !== 2'd2) begin
            n_fail++;
            $display("FAIL single_grant: vld=%b id=%0d, want vld=1 id=2", grant_vld, grant_id);
        end
        for (int k = 0; k < 6; k++) begin
            n_tests++;
            if (bus.winc !== 1'b1 || grant_id !== 2'd2) begin
                n_fail++;
                $display("FAIL single_stream[%0d]: winc=%b id=%0d, want winc=1 id=2",
                         k, bus.winc, grant_id);
            end
            cycle(); #1;
        end
        n_tests++;
        if (wq_data.size() !== 6) begin
            n_fail++;
            $display("FAIL single_count: got %0d writes, want 6", wq_data.size());
        end else begin
            for (int k = 0; k < 6; k++) begin
                n_tests++;
                if (wq_data[k] !== 8'(8'h20 + k) || wq_gid[k] !== 2'd2) begin
                    n_fail++;
                    $display("FAIL single_readback[%0d]: data=%h gid=%0d, want data=%h gid=2",
                             k, wq_data[k], wq_gid[k], 8'(8'h20 + k));
                end
            end
        end
        cycle(); #1;
        n_tests++;
        if (grant_vld !== 1'b0 || grant_id !== 2'd2) begin
            n_fail++;
            $display("FAIL single_idle: vld=%b id=%0d, want vld=0 id=2", grant_vld, grant_id);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_gid;
        logic [7:0] exp_data;
        do_reset();
        for (int i = 0; i < NREQ; i++) rem[i] = 8;
        apply_inputs();
        cycle(); #1;
        for (int k = 0; k < 20; k++) begin
            n_tests++;
            if (bus.winc !== 1'b1) begin
                n_fail++;
                $display("FAIL rr_no_bubble[%0d]: winc=%b, want 1", k, bus.winc);
            end
            cycle(); #1;
        end
        n_tests++;
        if (wq_data.size() !== 20) begin
            n_fail++;
            $display("FAIL rr_count: got %0d writes, want 20", wq_data.size());
        end else begin
            for (int k = 0; k < 20; k++) begin
                exp_gid  = 2'((k / 4) % 4);
                exp_data = 8'((int'(exp_gid) << 4) + (k / 16) * 4 + (k % 4));
                n_tests++;
                if (wq_gid[k] !== exp_gid || wq_data[k] !== exp_data) begin
                    n_fail++;
                    $display("FAIL rr_order[%0d]: gid=%0d data=%h, want gid=%0d data=%h",
                             k, wq_gid[k], wq_data[k], exp_gid, exp_data);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        rem[1] = 4;
        rem[2] = 2;
        apply_inputs();
        cycle(); #1;
        n_tests++;
        if (grant_id !== 2'd1 || bus.winc !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_grant: id=%0d winc=%b, want id=1 winc=1", grant_id, bus.winc);
        end
        cycle(); #1;
        cycle(); #1;
        bus.wfull = 1'b1;
        #1;
        for (int j = 0; j < 5; j++) begin
            n_tests++;
            if (bus.winc !== 1'b0 || bus.req_ready !== 4'b0000 || grant_id !== 2'd1) begin
                n_fail++;
                $display("FAIL bp_blocked[%0d]: winc=%b ready=%b id=%0d, want 0 0000 1",
                         j, bus.winc, bus.req_ready, grant_id);
            end
            cycle(); #1;
        end
        bus.wfull = 1'b0;
        #1;
        n_tests++;
        if (stall_cnt !== 16'd5 || bus.winc !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_stall_cnt: stall=%0d winc=%b, want stall=5 winc=1",
                     stall_cnt, bus.winc);
        end
        cycle(); #1;
        cycle(); #1;
        n_tests++;
        if (grant_vld !== 1'b1 || grant_id !== 2'd2) begin
            n_fail++;
            $display("FAIL bp_handoff: vld=%b id=%0d, want vld=1 id=2", grant_vld, grant_id);
        end
        n_tests++;
        if (wq_data.size() !== 4 || wq_data[0] !== 8'h10 || wq_data[3] !== 8'h13 ||
            wq_gid[3] !== 2'd1) begin
            n_fail++;
            $display("FAIL bp_words: n=%0d, want 4 writes 10..13 from requester 1",
                     wq_data.size());
        end
    endtask

    task automatic test_early_drop();
        do_reset();
        rem[3] = 5;
        apply_inputs();
        cycle(); #1;
        n_tests++;
        if (grant_id !== 2'd3 || bus.winc !== 1'b1) begin
            n_fail++;
            $display("FAIL drop_grant3: id=%0d winc=%b, want id=3 winc=1", grant_id, bus.winc);
        end
        cycle(); #1;
        hold[3] = 1'b1;
        rem[0]  = 6;
        rem[1]  = 2;
        apply_inputs();
        #1;
        n_tests++;
        if (bus.winc !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_no_write: winc=%b, want 0", bus.winc);
        end
        cycle(); #1;
        n_tests++;
        if (grant_id !== 2'd0 || bus.wdata !== 8'h00) begin
            n_fail++;
            $display("FAIL drop_pass0: id=%0d wdata=%h, want id=0 wdata=00", grant_id, bus.wdata);
        end
        for (int k = 0; k < 4; k++) begin
            n_tests++;
            if (bus.winc !== 1'b1 || grant_id !== 2'd0) begin
                n_fail++;
                $display("FAIL drop_burst[%0d]: winc=%b id=%0d, want winc=1 id=0",
                         k, bus.winc, grant_id);
            end
            cycle(); #1;
        end
        n_tests++;
        if (grant_id !== 2'd1 || wq_data.size() !== 5 || wq_data[4] !== 8'h03) begin
            n_fail++;
            $display("FAIL drop_burst_restart: id=%0d writes=%0d, want id=1 writes=5",
                     grant_id, wq_data.size());
        end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        rem[2] = 6;
        apply_inputs();
        cycle(); #1;
        cycle(); #1;
        bus.wfull = 1'b1;
        #1;
        cycle(); #1;
        bus.wfull = 1'b0;
        #1;
        n_tests++;
        if (stall_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL rmb_pre_stall: stall=%0d, want 1", stall_cnt);
        end
        cycle(); #1;
        wrst_n = 1'b0;
        rem[1] = 4;
        apply_inputs();
        #1;
        n_tests++;
        if (bus.winc !== 1'b0 || bus.req_ready !== 4'b0000) begin
            n_fail++;
            $display("FAIL rmb_no_write: winc=%b ready=%b, want 0 0000", bus.winc, bus.req_ready);
        end
        cycle(); #1;
        wrst_n = 1'b1;
        #1;
        n_tests++;
        if (grant_vld !== 1'b0 || stall_cnt !== 16'd0 || wq_data.size() !== 2) begin
            n_fail++;
            $display("FAIL rmb_after: vld=%b stall=%0d writes=%0d, want 0 0 2",
                     grant_vld, stall_cnt, wq_data.size());
        end
        cycle(); #1;
        n_tests++;
        if (grant_vld !== 1'b1 || grant_id !== 2'd1) begin
            n_fail++;
            $display("FAIL rmb_regrant: vld=%b id=%0d, want vld=1 id=1", grant_vld, grant_id);
        end
    endtask

    task automatic test_stall_saturation();
        do_reset();
        rem[0] = 1;
        bus.wfull = 1'b1;
        apply_inputs();
        cycle(); #1;
        repeat (65534) cycle();
        #1;
        n_tests++;
        if (stall_cnt !== 16'hFFFE || grant_id !== 2'd0) begin
            n_fail++;
            $display("FAIL sat_near: stall=%h id=%0d, want FFFE id=0", stall_cnt, grant_id);
        end
        cycle(); #1;
        n_tests++;
        if (stall_cnt !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL sat_reach: stall=%h, want FFFF", stall_cnt);
        end
        repeat (100) cycle();
        #1;
        n_tests++;
        if (stall_cnt !== 16'hFFFF || grant_vld !== 1'b1 || bus.winc !== 1'b0) begin
            n_fail++;
            $display("FAIL sat_hold: stall=%h vld=%b winc=%b, want FFFF 1 0",
                     stall_cnt, grant_vld, bus.winc);
        end
        bus.wfull = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        wrst_n = 1'b0;
        bus.wfull = 1'b0;
        bus.req_valid = '0;
        bus.req_data = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_early_drop();
        test_reset_mid_burst();
        test_stall_saturation();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/async_fifo_wr_arbiter.md
# async_fifo_wr_arbiter

Write-side arbiter for the async FIFO. It shares the single FIFO write port (wdata/winc/wfull) among NREQ requesters using round-robin arbitration with a per-grant burst limit. It lives entirely in the write clock domain and drives the FIFO write port directly. Transfer pacing follows wfull, so no write is ever issued to a full FIFO.

## Interface
Parameters:
- DSIZE, 8, data width; must match the FIFO `DSIZE`.
- NREQ, 4, number of requesters (2..8).
- BURST, 4, maximum consecutive transfers per grant (1..16).

Ports:
- wclk  in  1  write-domain clock.
- wrst_n  in  1  reset; one clock, synchronous, active-low.
- req_valid  in  NREQ  per-requester data valid.
- req_data  in  NREQ*DSIZE  requester i data at bits [i*DSIZE +: DSIZE].
- req_ready  out  NREQ  per-requester accept. Combinational.
- wfull  in  1  FIFO full flag.
- winc  out  1  FIFO write enable. Combinational.
- wdata  out  DSIZE  FIFO write data. Combinational mux.
- grant_vld  out  1  an owner currently holds the port. Registered.
- grant_id  out  $clog2(NREQ)  current owner index. Registered.
- stall_cnt  out  16  cycles the owner was blocked by wfull. Saturating.

## Operation
- Registered state:
  - owner (grant_id)
  - owner_vld (grant_vld)
  - burst_cnt [4:0]
  - stall_cnt
- States:
  - IDLE: owner_vld=0.
  - GRANT: owner_vld=1.
- Combinational outputs:
  - req_ready[i] = wrst_n && owner_vld && owner==i && !wfull.
  - A transfer (xfer) occurs when req_valid[owner] && req_ready[owner].
  - winc = xfer.
  - wdata = req_data slice of owner.
  - When owner_vld=0, wdata = 0.
- Release condition, evaluated at each edge: owner_vld && (!req_valid[owner] || (xfer && burst_cnt==BURST-1)).
- Arbitration at an edge when in IDLE or when the release condition holds:
  - Next owner is the first i with req_valid[i]=1, searching owner+1, owner+2, … modulo NREQ, ending at owner itself.
  - If one is found: owner_vld=1 and burst_cnt=0.
  - If none is found: owner_vld=0 and owner is unchanged.
  - A released owner that is the only valid requester is re-granted.
- Otherwise, in GRANT: burst_cnt increments on xfer and holds on stall.
- While wfull=1, the owner keeps the grant and burst_cnt holds. The grant is not released for wfull.
- stall_cnt increments on cycles where owner_vld && req_valid[owner] && wfull. It saturates at 0xFFFF.
- Requester handshake rules:
  - req_data must be held stable while req_valid=1 and not accepted.
  - A requester may drop req_valid before acceptance; this releases its grant at that edge.

## Timing
- Reset values (edge with wrst_n=0): owner_vld=0, owner=NREQ-1 (first search starts at 0), burst_cnt=0, stall_cnt=0.
- Hence grant_vld=0 and grant_id=NREQ-1 after reset.
- While wrst_n=0, winc=0 and req_ready=0 regardless of state.
- Reset mid-burst: the edge with wrst_n=0 aborts the grant. No write occurs in that cycle. Arbitration restarts from requester 0.
- Latency from IDLE: req_valid rises before edge E0 → grant_vld=1 after E0 → winc=1 in the following cycle → first write at edge E1.
- Throughput: one word per wclk while the owner is valid and wfull=0.
- Owner switch: zero bubble when another requester is valid at the release edge. A write from the new owner can occur in the next cycle.
- wfull is sampled combinationally. A FIFO that becomes full at edge E gates winc in the cycle after E. No overflow write is ever generated.
- Simultaneous release and new requests: the search uses req_valid as sampled at the release edge.

## Test plan
- Single requester, NREQ=4, BURST=4. req_valid[2] held with 6 words, FIFO empty.
  - grant_id=2 after edge 1.
  - winc on 6 consecutive cycles, with a re-grant to 2 after word 4 (no bubble).
  - FIFO read back returns the 6 words in order.
- Round-robin: all 4 requesters continuously valid.
  - Grant order 0,1,2,3,0.
  - Exactly 4 writes per grant.
  - No idle cycle at handoffs.
- Backpressure: force wfull=1 for 5 cycles mid-burst of requester 1 after 2 words.
  - winc=0 and req_ready=0 for those 5 cycles.
  - grant_id stays 1 and stall_cnt=5.
  - Remaining 2 words are written after wfull drops, then the grant moves on.
- Early drop: requester 3 granted, drops req_valid after 1 word while requester 0 is valid.
  - Grant passes to 0 at that edge.
  - burst_cnt restarts at 0.
- Reset mid-burst: wrst_n=0 for 1 cycle during requester 2's third word.
  - winc=0 in the reset cycle.
  - grant_vld=0 and stall_cnt=0 afterwards.
  - With 1 and 2 valid, the next grant goes to 1.
- Stall saturation: wfull=1 with owner valid for 70000 cycles → stall_cnt=0xFFFF and holds.
